// File: rtl/mem_arb_pkg.sv
// Shared types for the partial-sum memory arbiter.
// Requester id tag width and memory operation encoding.
package mem_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded id.
// Ports: clk, rst_n, req, advance (commit grant), grant, grant_id.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output req_id_t      grant_id
);

  req_id_t ptr;
  req_id_t nxt;
  logic    found;

  // Scan from ptr upward, wrapping, first requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k) % N == i)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = req_id_t'(i);
        end
      end
    end
  end

  always_comb begin
    if (int'(grant_id) == N - 1) nxt = '0;
    else nxt = grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= nxt;
  end

endmodule

// File: rtl/psum_mem_arbiter.sv
// Arbitrates N requesters onto one read and one write memory port.
// Ports: req_* handshake, rsp_* read return, mem_* registered memory port.
module psum_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int DATA_WIDTH         = 32,
  parameter int NUM_REQ            = 2
) (
  input  logic                               clk,
  input  logic                               arst_n_in,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ*LOG2_OF_MEM_HEIGHT-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic                               mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0]      mem_read_addr,
  input  logic [DATA_WIDTH-1:0]              mem_qout,
  output logic                               mem_we,
  output logic [LOG2_OF_MEM_HEIGHT-1:0]      mem_write_addr,
  output logic [DATA_WIDTH-1:0]              mem_din
);

  localparam int AW = LOG2_OF_MEM_HEIGHT;
  localparam int DW = DATA_WIDTH;
  localparam int N  = NUM_REQ;

  logic [N-1:0]  rd_req;
  logic [N-1:0]  wr_req;
  logic [N-1:0]  rd_gnt;
  logic [N-1:0]  wr_gnt;
  req_id_t       rd_id;
  req_id_t       wr_id;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          hazard;
  logic          rd_fire;
  logic          wr_fire;

  logic          tag1_vld;
  req_id_t       tag1_id;
  logic          tag2_vld;
  req_id_t       tag2_id;

  always_comb begin
    rd_req = '0;
    wr_req = '0;
    for (int i = 0; i < N; i++) begin
      rd_req[i] = req_valid[i] &&
                  (mem_op_e'(req_we[i]) == OP_READ);
      wr_req[i] = req_valid[i] &&
                  (mem_op_e'(req_we[i]) == OP_WRITE);
    end
  end

  rr_arbiter #(.N(N)) u_rd_arb (
    .clk      (clk),
    .rst_n    (arst_n_in),
    .req      (rd_req),
    .advance  (rd_fire),
    .grant    (rd_gnt),
    .grant_id (rd_id)
  );

  rr_arbiter #(.N(N)) u_wr_arb (
    .clk      (clk),
    .rst_n    (arst_n_in),
    .req      (wr_req),
    .advance  (wr_fire),
    .grant    (wr_gnt),
    .grant_id (wr_id)
  );

  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(rd_id) == i)
        rd_addr = req_addr[i*AW +: AW];
      if (int'(wr_id) == i) begin
        wr_addr = req_addr[i*AW +: AW];
        wr_data = req_wdata[i*DW +: DW];
      end
    end
  end

  // A read colliding with the write granted now, or with
  // the write sitting on the memory port, waits so it
  // observes the new data.
  assign hazard = (|wr_gnt && (wr_addr == rd_addr)) ||
                  (mem_we && (mem_write_addr == rd_addr));

  assign wr_fire = |wr_gnt && arst_n_in;
  assign rd_fire = |rd_gnt && !hazard && arst_n_in;

  assign req_ready = (rd_fire ? rd_gnt : '0) |
                     (wr_fire ? wr_gnt : '0);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem_re         <= 1'b0;
      mem_read_addr  <= '0;
      mem_we         <= 1'b0;
      mem_write_addr <= '0;
      mem_din        <= '0;
    end else begin
      mem_re         <= rd_fire;
      mem_read_addr  <= rd_fire ? rd_addr : '0;
      mem_we         <= wr_fire;
      mem_write_addr <= wr_fire ? wr_addr : '0;
      mem_din        <= wr_fire ? wr_data : '0;
    end
  end

  // Id tag follows each read: stage 1 with mem_re,
  // stage 2 with mem_qout.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      tag1_vld <= 1'b0;
      tag1_id  <= '0;
      tag2_vld <= 1'b0;
      tag2_id  <= '0;
    end else begin
      tag1_vld <= rd_fire;
      tag1_id  <= rd_id;
      tag2_vld <= tag1_vld;
      tag2_id  <= tag1_id;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N; i++)
      if (tag2_vld && (int'(tag2_id) == i))
        rsp_valid[i] = 1'b1;
  end

  assign rsp_data = tag2_vld ? mem_qout : '0;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Bench for psum_mem_arbiter: vector table, directed reset
// sequence and random traffic against a reference model.
module tb_psum_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            arst_n_in;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_re;
  logic [AW-1:0]   mem_read_addr;
  logic [DW-1:0]   mem_qout = '0;
  logic            mem_we;
  logic [AW-1:0]   mem_write_addr;
  logic [DW-1:0]   mem_din;

  always #5 clk = ~clk;

  psum_mem_arbiter #(
    .LOG2_OF_MEM_HEIGHT (AW),
    .DATA_WIDTH         (DW),
    .NUM_REQ            (N)
  ) dut (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .mem_re         (mem_re),
    .mem_read_addr  (mem_read_addr),
    .mem_qout       (mem_qout),
    .mem_we         (mem_we),
    .mem_write_addr (mem_write_addr),
    .mem_din        (mem_din)
  );

  // External memory: synchronous, read-before-write.
  logic [DW-1:0] dev_mem [256];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) dev_mem[pre_addr] <= pre_data;
    if (mem_we) dev_mem[mem_write_addr[7:0]] <= mem_din;
    if (mem_re) mem_qout <= dev_mem[mem_read_addr[7:0]];
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [256];
  rsp_t          rq[$];
  int            rd_ptr, wr_ptr, cyc;
  int            e_rid, e_wid;
  logic [N-1:0]  e_ready;
  logic          e_re, e_we;
  logic [AW-1:0] e_raddr, e_waddr;
  logic [DW-1:0] e_din;

  function automatic bit is_req(int i, bit wr);
    logic [N-1:0] v, w;
    v = req_valid >> i;
    w = req_we >> i;
    return v[0] && (w[0] == wr);
  endfunction

  function automatic logic [AW-1:0] addr_of(int i);
    logic [N*AW-1:0] t;
    t = req_addr >> (i * AW);
    return t[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] data_of(int i);
    logic [N*DW-1:0] t;
    t = req_wdata >> (i * DW);
    return t[DW-1:0];
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  task automatic model_reset();
    rd_ptr = 0;
    wr_ptr = 0;
    rq.delete();
    e_re = 1'b0;
    e_we = 1'b0;
    e_raddr = '0;
    e_waddr = '0;
    e_din = '0;
  endtask

  task automatic model_grants();
    int i;
    logic [AW-1:0] ra;
    e_rid = -1;
    e_wid = -1;
    for (int k = 0; k < N; k++) begin
      i = (rd_ptr + k) % N;
      if (e_rid < 0 && is_req(i, 1'b0)) e_rid = i;
      i = (wr_ptr + k) % N;
      if (e_wid < 0 && is_req(i, 1'b1)) e_wid = i;
    end
    if (e_rid >= 0) begin
      ra = addr_of(e_rid);
      if ((e_wid >= 0 && addr_of(e_wid) == ra) ||
          (e_we && e_waddr == ra))
        e_rid = -1;
    end
    e_ready = '0;
    if (e_rid >= 0) e_ready |= onehot(e_rid);
    if (e_wid >= 0) e_ready |= onehot(e_wid);
  endtask

  task automatic model_update();
    e_re = (e_rid >= 0);
    e_we = (e_wid >= 0);
    if (e_re) begin
      e_raddr = addr_of(e_rid);
      rq.push_back('{cyc + 2, e_rid,
                     ref_mem[e_raddr[7:0]]});
      rd_ptr = (e_rid + 1) % N;
    end
    if (e_we) begin
      e_waddr = addr_of(e_wid);
      e_din = data_of(e_wid);
      ref_mem[e_waddr[7:0]] = e_din;
      wr_ptr = (e_wid + 1) % N;
    end
    cyc++;
  endtask

  // One clock: check at negedge, model steps at posedge,
  // caller drives the next inputs 1 time unit later.
  task automatic cycle(output logic [N-1:0] rdy,
                       output logic [N-1:0] rv,
                       output logic [DW-1:0] rd,
                       output logic [1:0] mp);
    logic [N-1:0] ev;
    @(negedge clk);
    model_grants();
    rdy = req_ready;
    rv  = rsp_valid;
    rd  = rsp_data;
    mp  = {mem_we, mem_re};
    chk("req_ready", req_ready, e_ready);
    chk("mem_re", mem_re, e_re);
    chk("mem_we", mem_we, e_we);
    if (e_re) chk("mem_read_addr", mem_read_addr, e_raddr);
    if (e_we) begin
      chk("mem_write_addr", mem_write_addr, e_waddr);
      chk("mem_din", mem_din, e_din);
    end
    ev = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev = onehot(rq[0].id);
      chk("rsp_data", rsp_data, rq[0].data);
      void'(rq.pop_front());
    end
    chk("rsp_valid", rsp_valid, ev);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(logic [1:0] v, logic [1:0] we,
                       logic [AW-1:0] a0, logic [AW-1:0] a1,
                       logic [DW-1:0] d0, logic [DW-1:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, req_ready, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_mem_re"}, mem_re, '0);
    chk({tag, "_mem_raddr"}, mem_read_addr, '0);
    chk({tag, "_mem_we"}, mem_we, '0);
    chk({tag, "_mem_waddr"}, mem_write_addr, '0);
    chk({tag, "_mem_din"}, mem_din, '0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    v, we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    rdy, rv;
    logic [DW-1:0] rd;
    logic [1:0]    mp;
  } vec_t;

  function automatic vec_t mk(
    logic [1:0] v, logic [1:0] we,
    logic [AW-1:0] a0, logic [AW-1:0] a1,
    logic [DW-1:0] d0, logic [1:0] rdy,
    logic [1:0] rv, logic [DW-1:0] rd,
    logic [1:0] mp);
    return '{v, we, a0, a1, d0, '0, rdy, rv, rd, mp};
  endfunction

  vec_t tbl[27];

  initial begin
    logic [N-1:0]  rdy, rv;
    logic [DW-1:0] rd;
    logic [1:0]    mp;
    logic [AW-1:0] ra0, ra1;

    // single read of 0x10
    tbl[0]  = mk(2'b01, 2'b00, 'h10, 'h0, 0, 2'b01, 2'b00, 0, 2'b00);
    tbl[1]  = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b00, 0, 2'b01);
    tbl[2]  = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b01, 'hDEAD, 2'b00);
    // req1 alone, returns pointer to req0
    tbl[3]  = mk(2'b10, 2'b00, 'h0, 'h60, 0, 2'b10, 2'b00, 0, 2'b00);
    // fairness: both read for 8 cycles
    for (int r = 4; r < 12; r++) begin
      tbl[r] = mk(2'b11, 2'b00, 'h50, 'h60, 0,
                  (r % 2 == 0) ? 2'b01 : 2'b10,
                  (r % 2 == 0) ? 2'b01 : 2'b10,
                  (r % 2 == 0) ? 'h5050 : 'h6060, 2'b01);
    end
    tbl[4].rv = 2'b00;
    tbl[4].rd = 0;
    tbl[12] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b01, 'h5050, 2'b01);
    tbl[13] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b10, 'h6060, 2'b00);
    // parallel classes
    tbl[14] = mk(2'b11, 2'b01, 'h20, 'h30, 5, 2'b11, 2'b00, 0, 2'b00);
    tbl[15] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b00, 0, 2'b11);
    tbl[16] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b10, 'h3030, 2'b00);
    // same-cycle hazard on 0x40
    tbl[17] = mk(2'b11, 2'b01, 'h40, 'h40, 7, 2'b01, 2'b00, 0, 2'b00);
    tbl[18] = mk(2'b10, 2'b00, 'h0, 'h40, 0, 2'b00, 2'b00, 0, 2'b10);
    tbl[19] = mk(2'b10, 2'b00, 'h0, 'h40, 0, 2'b10, 2'b00, 0, 2'b00);
    tbl[20] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b00, 0, 2'b01);
    tbl[21] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b10, 7, 2'b00);
    // registered-write hazard on 0x70
    tbl[22] = mk(2'b01, 2'b01, 'h70, 'h0, 9, 2'b01, 2'b00, 0, 2'b00);
    tbl[23] = mk(2'b10, 2'b00, 'h0, 'h70, 0, 2'b00, 2'b00, 0, 2'b10);
    tbl[24] = mk(2'b10, 2'b00, 'h0, 'h70, 0, 2'b10, 2'b00, 0, 2'b00);
    tbl[25] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b00, 0, 2'b01);
    tbl[26] = mk(2'b00, 2'b00, 'h0, 'h0, 0, 2'b00, 2'b10, 9, 2'b00);

    for (int a = 0; a < 256; a++) ref_mem[a] = '0;
    ref_mem['h10] = 'hDEAD;
    ref_mem['h30] = 'h3030;
    ref_mem['h50] = 'h5050;
    ref_mem['h60] = 'h6060;

    // reset with requests pending: everything stays 0
    arst_n_in = 1'b0;
    drive(2'b11, 2'b01, 'h1, 'h2, 1, 2);
    for (int a = 0; a < 256; a++) begin
      pre_we = 1'b1;
      pre_addr = 8'(a);
      pre_data = ref_mem[a];
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    arst_n_in = 1'b1;
    model_reset();
    cyc = 0;

    for (int r = 0; r < 27; r++) begin
      drive(tbl[r].v, tbl[r].we, tbl[r].a0, tbl[r].a1,
            tbl[r].d0, tbl[r].d1);
      cycle(rdy, rv, rd, mp);
      chk($sformatf("tbl%0d_ready", r), rdy, tbl[r].rdy);
      chk($sformatf("tbl%0d_rsp_valid", r), rv, tbl[r].rv);
      chk($sformatf("tbl%0d_mem_we_re", r), mp, tbl[r].mp);
      if (tbl[r].rv != 0)
        chk($sformatf("tbl%0d_rsp_data", r), rd, tbl[r].rd);
    end

    // two reads from req0 in flight, pointer left at req1
    drive(2'b01, 2'b00, 'h10, 'h0, 0, 0);
    cycle(rdy, rv, rd, mp);
    chk("pre_rst_rd0", rdy, 2'b01);
    drive(2'b01, 2'b00, 'h50, 'h0, 0, 0);
    cycle(rdy, rv, rd, mp);
    chk("pre_rst_rd1", rdy, 2'b01);
    drive(2'b11, 2'b00, 'h10, 'h60, 0, 0);
    #2;
    arst_n_in = 1'b0;
    model_reset();
    #1;
    chk_zero("rst_async");
    @(negedge clk);
    chk_zero("rst_hold");
    @(posedge clk);
    #1;
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    arst_n_in = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cycle(rdy, rv, rd, mp);
      chk("post_rst_rsp", rv, 2'b00);
    end
    drive(2'b11, 2'b00, 'h10, 'h60, 0, 0);
    cycle(rdy, rv, rd, mp);
    chk("post_rst_first_grant", rdy, 2'b01);

    // random traffic on a tiny address range for hazards
    for (int r = 0; r < 600; r++) begin
      ra0 = AW'($urandom_range(3));
      ra1 = AW'($urandom_range(3));
      drive(2'($urandom), 2'($urandom), ra0, ra1,
            $urandom, $urandom);
      cycle(rdy, rv, rd, mp);
    end
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) cycle(rdy, rv, rd, mp);
    chk("rsp_drained", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
